// File: rtl/writeback_regfile_if.sv
// Commit bus from the execute/memory side into the register-file write stage.
interface writeback_regfile_if #(
  parameter int DATA_W = 64
);
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        icode_i;
  logic [3:0]        ra_i;
  logic [3:0]        rb_i;
  logic              cnd_i;
  logic [DATA_W-1:0] vale_i;
  logic [DATA_W-1:0] valm_i;

  modport master (
    output valid_i, icode_i, ra_i, rb_i, cnd_i, vale_i, valm_i,
    input  ready_o
  );

  modport slave (
    input  valid_i, icode_i, ra_i, rb_i, cnd_i, vale_i, valm_i,
    output ready_o
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 register file write side: decodes dstE/dstM from the committed
// instruction, writes valE/valM, exposes two combinational read ports and
// tracks machine status (AOK/HLT/INS), freezing all writes after halt/illegal.
module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  writeback_regfile_if.slave cmt,
  input  logic [3:0]        srca_i,
  input  logic [3:0]        srcb_i,
  output logic [DATA_W-1:0] vala_o,
  output logic [DATA_W-1:0] valb_o,
  output logic [2:0]        stat_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] R_RSP    = 4'h4;

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic [3:0]               dst_e, dst_m;
  logic                     illegal;
  logic                     accept;
  logic                     e_hit, m_hit, same_hit;
  logic [1:0]               n_wr;
  logic [NREG-1:0][DATA_W-1:0] reg_file;

  // Destination decode from the committed instruction.
  always_comb begin
    dst_e   = R_NONE;
    dst_m   = R_NONE;
    illegal = 1'b0;
    case (cmt.icode_i)
      I_HALT, I_NOP, I_RMMOVQ, I_JXX: ;
      I_CMOVXX:                dst_e = cmt.cnd_i ? cmt.rb_i : R_NONE;
      I_IRMOVQ, I_OPQ:         dst_e = cmt.rb_i;
      I_MRMOVQ:                dst_m = cmt.ra_i;
      I_CALL, I_RET, I_PUSHQ:  dst_e = R_RSP;
      I_POPQ: begin
        dst_e = R_RSP;
        dst_m = cmt.ra_i;
      end
      default:                 illegal = 1'b1;
    endcase
  end

  // Write enables and the number of distinct registers touched this edge.
  always_comb begin
    accept   = cmt.valid_i && (state_q == ST_RUN);
    e_hit    = accept && !illegal && (dst_e != R_NONE);
    m_hit    = accept && !illegal && (dst_m != R_NONE);
    same_hit = e_hit && m_hit && (dst_e == dst_m);
    n_wr     = {1'b0, e_hit} + {1'b0, m_hit} - {1'b0, same_hit};
    wr_cnt_d = wr_cnt_q + {{(CNT_W-2){1'b0}}, n_wr};
  end

  // Status FSM next state and status outputs.
  always_comb begin
    state_d     = state_q;
    stat_o      = 3'd1;
    cmt.ready_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        cmt.ready_o = 1'b1;
        if (cmt.valid_i) begin
          if (illegal)                     state_d = ST_ERROR;
          else if (cmt.icode_i == I_HALT)  state_d = ST_HALTED;
        end
      end
      ST_HALTED: stat_o = 3'd2;
      ST_ERROR:  stat_o = 3'd4;
      default:   state_d = ST_ERROR;
    endcase
  end

  // State register and committed-write counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;

  // One storage slot per architectural register; valM has priority over valE.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q, r_d;

    // Next value for this register.
    always_comb begin
      r_d = r_q;
      if (m_hit && (dst_m == 4'(gi)))      r_d = cmt.valm_i;
      else if (e_hit && (dst_e == 4'(gi))) r_d = cmt.vale_i;
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_q <= '0;
      else          r_q <= r_d;
    end

    assign reg_file[gi] = r_q;
  end

  // Combinational read ports; ID f reads as zero, no same-cycle bypass.
  always_comb begin
    vala_o = '0;
    valb_o = '0;
    if (srca_i != R_NONE) vala_o = reg_file[srca_i];
    if (srcb_i != R_NONE) valb_o = reg_file[srcb_i];
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic [3:0]  srca, srcb;
  logic [63:0] vala, valb;
  logic [2:0]  stat;
  logic [15:0] wr_cnt;

  writeback_regfile_if #(.DATA_W(64)) bus ();

  writeback_regfile #(.DATA_W(64), .NREG(15), .CNT_W(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .cmt      (bus.slave),
    .srca_i   (srca),
    .srcb_i   (srcb),
    .vala_o   (vala),
    .valb_o   (valb),
    .stat_o   (stat),
    .wr_cnt_o (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 port A, 1 port B, 2 stat, 3 wr_cnt, 4 ready
    logic [3:0]  id;
    logic [63:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_tx  = 0;

  // reference model
  logic [63:0] mreg [16];
  logic [15:0] mcnt;
  logic [2:0]  mstat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mcnt  = '0;
    mstat = 3'd1;
  endtask

  task automatic push_all();
    exp_t x;
    for (int i = 0; i < 16; i++) begin
      x.tag = $sformatf("rdA_r%0d", i); x.kind = 0; x.id = 4'(i);      x.val = mreg[i];      sb_q.push_back(x);
      x.tag = $sformatf("rdB_r%0d", 15-i); x.kind = 1; x.id = 4'(15-i); x.val = mreg[15-i]; sb_q.push_back(x);
    end
    x.tag = "stat";  x.kind = 2; x.id = 0; x.val = 64'(mstat);               sb_q.push_back(x);
    x.tag = "wr_cnt"; x.kind = 3; x.id = 0; x.val = 64'(mcnt);               sb_q.push_back(x);
    x.tag = "ready"; x.kind = 4; x.id = 0; x.val = 64'(mstat == 3'd1);       sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      case (x.kind)
        0: begin srca = x.id; #1; check(x.tag, vala, x.val); end
        1: begin srcb = x.id; #1; check(x.tag, valb, x.val); end
        2: check(x.tag, 64'(stat), x.val);
        3: check(x.tag, 64'(wr_cnt), x.val);
        default: check(x.tag, 64'(bus.ready_o), x.val);
      endcase
    end
  endtask

  task automatic apply(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic cnd, input logic [63:0] ve, input logic [63:0] vm);
    logic [3:0] e, m;
    logic       ill;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.icode_i = ic; bus.ra_i = ra; bus.rb_i = rb;
    bus.cnd_i = cnd; bus.vale_i = ve; bus.valm_i = vm;
    srca = rb; srcb = ra;
    #1;
    check("nobyp_a", vala, mreg[rb]);
    check("nobyp_b", valb, mreg[ra]);
    e = 4'hf; m = 4'hf; ill = 1'b0;
    case (ic)
      4'h0, 4'h1, 4'h4, 4'h7: ;
      4'h2: e = cnd ? rb : 4'hf;
      4'h3, 4'h6: e = rb;
      4'h5: m = ra;
      4'h8, 4'h9, 4'hA: e = 4'h4;
      4'hB: begin e = 4'h4; m = ra; end
      default: ill = 1'b1;
    endcase
    if (mstat == 3'd1) begin
      if (ill) mstat = 3'd4;
      else begin
        if (ic == 4'h0) mstat = 3'd2;
        if (e != 4'hf) begin mreg[e] = ve; mcnt = mcnt + 16'd1; end
        if (m != 4'hf) begin
          mreg[m] = vm;
          if (m != e) mcnt = mcnt + 16'd1;
        end
      end
    end
    push_all();
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    drain();
    n_tx++;
    $display("tx %0d icode=%h ra=%h rb=%h cnd=%0d vale=%h valm=%h -> stat=%0d cnt=%0d",
             n_tx, ic, ra, rb, cnd, ve, vm, stat, wr_cnt);
  endtask

  initial begin
    logic [3:0] ic;
    bus.valid_i = 1'b0; bus.icode_i = 4'h1; bus.ra_i = 4'hf; bus.rb_i = 4'hf;
    bus.cnd_i = 1'b0; bus.vale_i = '0; bus.valm_i = '0;
    srca = 4'hf; srcb = 4'hf;
    rst_n = 1'b0;
    model_reset();
    #12;
    push_all();
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    apply(4'h3, 4'hf, 4'h2, 1'b0, 64'h1234, 64'h0);
    apply(4'h2, 4'h1, 4'h3, 1'b0, 64'hAA, 64'h0);
    apply(4'h2, 4'h1, 4'h3, 1'b1, 64'hAA, 64'h0);
    apply(4'hB, 4'h5, 4'hf, 1'b0, 64'h208, 64'hBEEF);
    apply(4'hB, 4'h4, 4'hf, 1'b0, 64'h208, 64'h77);
    apply(4'h5, 4'he, 4'hf, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(4'h2, 4'h1, 4'hf, 1'b1, 64'h55, 64'h0);
    apply(4'h4, 4'h7, 4'h8, 1'b0, 64'h99, 64'h98);

    // randomized legal, non-halting instructions
    for (int k = 0; k < 14; k++) begin
      ic = 4'($urandom_range(1, 11));
      apply(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom});
    end

    // idle cycles in RUN must not write
    @(negedge clk);
    bus.icode_i = 4'h3; bus.rb_i = 4'h6; bus.vale_i = 64'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    push_all();
    drain();

    // halt freezes everything
    apply(4'h0, 4'hf, 4'hf, 1'b0, 64'h0, 64'h0);
    apply(4'h3, 4'hf, 4'h6, 1'b0, 64'h9, 64'h0);
    apply(4'hB, 4'h6, 4'hf, 1'b0, 64'h1, 64'h2);

    // reset mid-cycle, away from any edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_all();
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'h3, 4'hf, 4'h6, 1'b0, 64'h9, 64'h0);
    apply(4'hA, 4'h2, 4'hf, 1'b0, 64'h100, 64'h0);
    apply(4'hC, 4'h1, 4'h2, 1'b1, 64'h33, 64'h44);
    apply(4'h3, 4'hf, 4'h7, 1'b0, 64'h11, 64'h0);
    apply(4'hF, 4'h1, 4'h2, 1'b1, 64'h33, 64'h44);

    // reset mid-cycle out of ERROR
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_all();
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'hB, 4'h4, 4'hf, 1'b0, 64'h1, 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
